// File: rtl/keypad_pkg.sv
// Shared types and constants for the 4x4 matrix keypad scanner.
package keypad_pkg;

    // Debounce/acceptance state machine states
    typedef enum logic [1:0] {
        IDLE,
        PRESS_DEB,
        HELD,
        REL_DEB
    } state_t;

    // Classification of one complete four-column scan
    typedef enum logic [1:0] {
        NONE,
        SINGLE,
        MULTI
    } scan_kind_t;

    // Hex code for each intersection, indexed {row,col}; row 0 / col 0 is entry 0.
    //   row 0: 1 2 3 A
    //   row 1: 4 5 6 B
    //   row 2: 7 8 9 C
    //   row 3: 0 F E D
    localparam logic [15:0][3:0] KEY_MAP = {
        4'hD, 4'hE, 4'hF, 4'h0,
        4'hC, 4'h9, 4'h8, 4'h7,
        4'hB, 4'h6, 4'h5, 4'h4,
        4'hA, 4'h3, 4'h2, 4'h1
    };

    // Number of digits the entry register holds; digit_cnt saturates here
    localparam logic [3:0] DIGIT_MAX = 4'd8;

endpackage

// File: rtl/keypad_colscan.sv
// Column driver, row synchronizer and per-scan result assembly.
module keypad_colscan
    import keypad_pkg::*;
#(
    parameter int SCAN_DIV = 50000
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [3:0] row,
    output logic [3:0] col,
    output logic       scan_done,
    output scan_kind_t scan_kind,
    output logic [3:0] scan_code
);

    localparam int DIV_W = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;

    logic [DIV_W-1:0] div;
    logic [1:0]       idx;
    logic [3:0]       row_meta;
    logic [3:0]       row_sync;
    logic [3:0][3:0]  samp;
    logic             col_end;

    assign col_end = (div == DIV_W'(SCAN_DIV - 1));
    assign col     = ~(4'b0001 << idx);

    // Two-flop synchronizer for the asynchronous, pulled-up row inputs
    always_ff @(posedge clk) begin
        if (rst) begin
            row_meta <= 4'hF;
            row_sync <= 4'hF;
        end else begin
            row_meta <= row;
            row_sync <= row_meta;
        end
    end

    // Column period divider; the active column advances at the end of each period
    always_ff @(posedge clk) begin
        if (rst) begin
            div <= '0;
            idx <= 2'd0;
        end else if (col_end) begin
            div <= '0;
            idx <= idx + 2'd1;
        end else begin
            div <= div + DIV_W'(1);
        end
    end

    // Capture the row state of the active column and flag the end of column 3
    always_ff @(posedge clk) begin
        if (rst) begin
            samp      <= '1;
            scan_done <= 1'b0;
        end else begin
            scan_done <= col_end && (idx == 2'd3);
            if (col_end) begin
                samp[idx] <= row_sync;
            end
        end
    end

    // Classify the four captured columns; held stable while scan_done is high
    always_comb begin
        logic [4:0] hits;
        logic [3:0] hit_idx;
        hits      = 5'd0;
        hit_idx   = 4'd0;
        scan_kind = NONE;
        for (int r = 0; r < 4; r++) begin
            for (int c = 0; c < 4; c++) begin
                if (!samp[c][r]) begin
                    hits    = hits + 5'd1;
                    hit_idx = 4'(r * 4 + c);
                end
            end
        end
        if (hits == 5'd1) begin
            scan_kind = SINGLE;
        end else if (hits > 5'd1) begin
            scan_kind = MULTI;
        end
        scan_code = KEY_MAP[hit_idx];
    end

endmodule

// File: rtl/keypad_scan.sv
// Keypad front end: debounce FSM, key strobe and 32-bit hex entry register.
module keypad_scan
    import keypad_pkg::*;
#(
    parameter int SCAN_DIV  = 50000,
    parameter int DEB_SCANS = 4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [3:0]  row,
    output logic [3:0]  col,
    input  logic        clear,
    output logic [3:0]  key_code,
    output logic        key_valid,
    output logic        key_held,
    output logic [31:0] data,
    output logic [3:0]  digit_cnt
);

    localparam logic [3:0] DEB = 4'(DEB_SCANS);

    state_t     state, state_n;
    logic [3:0] cnt, cnt_n, cnt_inc;
    logic [3:0] cand, cand_n;
    logic       accept;
    logic       held_n;
    logic       is_cand;

    logic       scan_done;
    scan_kind_t scan_kind;
    logic [3:0] scan_code;

    keypad_colscan #(
        .SCAN_DIV (SCAN_DIV)
    ) u_colscan (
        .clk       (clk),
        .rst       (rst),
        .row       (row),
        .col       (col),
        .scan_done (scan_done),
        .scan_kind (scan_kind),
        .scan_code (scan_code)
    );

    assign is_cand = (scan_kind == SINGLE) && (scan_code == cand);
    assign cnt_inc = cnt + 4'd1;
    assign held_n  = (state_n == HELD) || (state_n == REL_DEB);

    // Next-state logic; the FSM only moves when a full scan has been classified
    always_comb begin
        state_n = state;
        cnt_n   = cnt;
        cand_n  = cand;
        accept  = 1'b0;
        if (scan_done) begin
            case (state)
                IDLE: begin
                    if (scan_kind == SINGLE) begin
                        cand_n = scan_code;
                        cnt_n  = 4'd1;
                        if (DEB <= 4'd1) begin
                            state_n = HELD;
                            accept  = 1'b1;
                        end else begin
                            state_n = PRESS_DEB;
                        end
                    end
                end
                PRESS_DEB: begin
                    if (is_cand) begin
                        cnt_n = cnt_inc;
                        if (cnt_inc >= DEB) begin
                            state_n = HELD;
                            accept  = 1'b1;
                        end
                    end else begin
                        cnt_n   = 4'd0;
                        state_n = IDLE;
                    end
                end
                HELD: begin
                    if (!is_cand) begin
                        cnt_n = 4'd1;
                        if ((scan_kind == NONE) && (DEB <= 4'd1)) begin
                            cnt_n   = 4'd0;
                            state_n = IDLE;
                        end else begin
                            state_n = REL_DEB;
                        end
                    end
                end
                REL_DEB: begin
                    if (scan_kind == NONE) begin
                        cnt_n = cnt_inc;
                        if (cnt_inc >= DEB) begin
                            cnt_n   = 4'd0;
                            state_n = IDLE;
                        end
                    end else if (is_cand) begin
                        state_n = HELD;
                    end else begin
                        cnt_n = 4'd0;
                    end
                end
                default: begin
                    state_n = IDLE;
                    cnt_n   = 4'd0;
                end
            endcase
        end
    end

    // FSM, debounce counter and candidate key registers
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
            cnt   <= 4'd0;
            cand  <= 4'd0;
        end else begin
            state <= state_n;
            cnt   <= cnt_n;
            cand  <= cand_n;
        end
    end

    // Outputs and entry register; clear beats a simultaneous accept for data/digit_cnt
    always_ff @(posedge clk) begin
        if (rst) begin
            key_code  <= 4'd0;
            key_valid <= 1'b0;
            key_held  <= 1'b0;
            data      <= 32'd0;
            digit_cnt <= 4'd0;
        end else begin
            key_valid <= accept;
            key_held  <= held_n;
            if (accept) begin
                key_code <= cand_n;
            end
            if (clear) begin
                data      <= 32'd0;
                digit_cnt <= 4'd0;
            end else if (accept) begin
                data      <= {data[27:0], cand_n};
                digit_cnt <= (digit_cnt >= DIGIT_MAX) ? DIGIT_MAX : digit_cnt + 4'd1;
            end
        end
    end

endmodule

// File: tb/tb_keypad_scan.sv
// Directed self-checking bench for keypad_scan with a behavioural keypad matrix.
module tb_keypad_scan;

    localparam int SCAN_DIV  = 4;
    localparam int DEB_SCANS = 2;

    logic        clk = 1'b0;
    logic        rst;
    logic        clear;
    logic [3:0]  row;
    logic [3:0]  col;
    logic [3:0]  key_code;
    logic        key_valid;
    logic        key_held;
    logic [31:0] data;
    logic [3:0]  digit_cnt;

    logic [15:0] keys;
    int          checks = 0;
    int          failures = 0;
    int          valid_total = 0;
    int          base;

    keypad_scan #(
        .SCAN_DIV  (SCAN_DIV),
        .DEB_SCANS (DEB_SCANS)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .row       (row),
        .col       (col),
        .clear     (clear),
        .key_code  (key_code),
        .key_valid (key_valid),
        .key_held  (key_held),
        .data      (data),
        .digit_cnt (digit_cnt)
    );

    always #5 clk = ~clk;

    // Keypad model: a pressed key pulls its row low while its column is driven low
    always_comb begin
        row = 4'hF;
        for (int c = 0; c < 4; c++) begin
            if (!col[c]) begin
                for (int r = 0; r < 4; r++) begin
                    if (keys[r * 4 + c]) row[r] = 1'b0;
                end
            end
        end
    end

    // Count every key_valid pulse
    always @(posedge clk) begin
        if (key_valid) valid_total <= valid_total + 1;
    end

    // Matrix position of a hex key, as a one-hot over {row,col}
    function automatic logic [15:0] key_bit(input logic [3:0] k);
        int pos;
        case (k)
            4'h1: pos = 0;   4'h2: pos = 1;   4'h3: pos = 2;   4'hA: pos = 3;
            4'h4: pos = 4;   4'h5: pos = 5;   4'h6: pos = 6;   4'hB: pos = 7;
            4'h7: pos = 8;   4'h8: pos = 9;   4'h9: pos = 10;  4'hC: pos = 11;
            4'h0: pos = 12;  4'hF: pos = 13;  4'hE: pos = 14;  default: pos = 15;
        endcase
        return 16'(1) << pos;
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            failures++;
            $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Return in the first cycle of a new scan (col just went 0111 -> 1110), n times
    task automatic wait_scan(input int n);
        for (int i = 0; i < n; i++) begin
            logic [3:0] c0;
            logic       found;
            found = 1'b0;
            c0    = col;
            for (int t = 0; t < 64 && !found; t++) begin
                @(negedge clk);
                if (c0 == 4'b0111 && col == 4'b1110) found = 1'b1;
                c0 = col;
            end
            check("scan_boundary", {31'd0, found}, 32'd1);
        end
    endtask

    task automatic press_key(input logic [3:0] k);
        keys = key_bit(k);
        wait_scan(3);
        keys = 16'd0;
        wait_scan(3);
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_col"},       {28'd0, col},       32'h0000000E);
        check({tag, "_key_code"},  {28'd0, key_code},  32'd0);
        check({tag, "_key_valid"}, {31'd0, key_valid}, 32'd0);
        check({tag, "_key_held"},  {31'd0, key_held},  32'd0);
        check({tag, "_data"},      data,               32'd0);
        check({tag, "_digit_cnt"}, {28'd0, digit_cnt}, 32'd0);
    endtask

    initial begin
        logic [3:0] col_seq [4];
        col_seq = '{4'b1101, 4'b1011, 4'b0111, 4'b1110};
        rst   = 1'b1;
        clear = 1'b0;
        keys  = 16'd0;

        // Reset and column rotation
        repeat (3) @(posedge clk);
        @(negedge clk);
        check_reset_outputs("reset");
        rst = 1'b0;
        for (int i = 0; i < 4; i++) begin
            repeat (4) @(negedge clk);
            check("col_rotate", {28'd0, col}, {28'd0, col_seq[i]});
        end

        // Single press of key 6 held for five scans
        base = valid_total;
        keys = key_bit(4'h6);
        wait_scan(5);
        check("single_held", {31'd0, key_held}, 32'd1);
        check("single_count", valid_total - base, 32'd1);
        check("single_code", {28'd0, key_code}, 32'h6);
        check("single_data", data, 32'h00000006);
        check("single_cnt", {28'd0, digit_cnt}, 32'd1);
        keys = 16'd0;
        wait_scan(2);
        check("release_held_before", {31'd0, key_held}, 32'd1);
        @(negedge clk);
        check("release_held_after", {31'd0, key_held}, 32'd0);
        wait_scan(1);

        // Bounce: key 5 for a single scan only
        base = valid_total;
        keys = key_bit(4'h5);
        wait_scan(1);
        keys = 16'd0;
        wait_scan(3);
        check("bounce_count", valid_total - base, 32'd0);
        check("bounce_data", data, 32'h00000006);
        check("bounce_held", {31'd0, key_held}, 32'd0);

        // Multi-key: 1 and 2 together, then 2 released
        base = valid_total;
        keys = key_bit(4'h1) | key_bit(4'h2);
        wait_scan(4);
        check("multi_count", valid_total - base, 32'd0);
        check("multi_held", {31'd0, key_held}, 32'd0);
        keys = key_bit(4'h1);
        wait_scan(3);
        check("multi_rel_count", valid_total - base, 32'd1);
        check("multi_rel_code", {28'd0, key_code}, 32'h1);
        check("multi_rel_data", data, 32'h00000061);
        check("multi_rel_cnt", {28'd0, digit_cnt}, 32'd2);
        keys = 16'd0;
        wait_scan(3);

        // Entry of digits 1..9 with digit_cnt saturation
        base = valid_total;
        for (int d = 1; d <= 9; d++) press_key(4'(d));
        check("entry_count", valid_total - base, 32'd9);
        check("entry_data", data, 32'h23456789);
        check("entry_cnt", {28'd0, digit_cnt}, 32'd8);

        // Clear coincident with the accept of key A
        base = valid_total;
        keys = key_bit(4'hA);
        wait_scan(2);
        clear = 1'b1;
        @(negedge clk);
        clear = 1'b0;
        check("clr_valid", {31'd0, key_valid}, 32'd1);
        check("clr_code", {28'd0, key_code}, 32'hA);
        check("clr_data", data, 32'd0);
        check("clr_cnt", {28'd0, digit_cnt}, 32'd0);
        @(negedge clk);
        check("clr_valid_pulse", {31'd0, key_valid}, 32'd0);
        wait_scan(1);
        keys = 16'd0;
        wait_scan(3);
        check("clr_count", valid_total - base, 32'd1);
        check("clr_data_hold", data, 32'd0);
        check("clr_cnt_hold", {28'd0, digit_cnt}, 32'd0);

        // Reset while key 9 is held, key stays down through reset
        keys = key_bit(4'h9);
        wait_scan(3);
        check("pre_rst_held", {31'd0, key_held}, 32'd1);
        check("pre_rst_data", data, 32'h00000009);
        rst = 1'b1;
        repeat (2) @(negedge clk);
        check_reset_outputs("midrst");
        base = valid_total;
        rst  = 1'b0;
        wait_scan(1);
        @(negedge clk);
        check("rst_no_early", valid_total - base, 32'd0);
        wait_scan(2);
        check("rst_reaccept_count", valid_total - base, 32'd1);
        check("rst_reaccept_code", {28'd0, key_code}, 32'h9);
        check("rst_reaccept_data", data, 32'h00000009);
        check("rst_reaccept_cnt", {28'd0, digit_cnt}, 32'd1);
        check("rst_reaccept_held", {31'd0, key_held}, 32'd1);
        wait_scan(2);
        check("no_repeat", valid_total - base, 32'd1);
        keys = 16'd0;
        wait_scan(3);
        check("final_held", {31'd0, key_held}, 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
